load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 39 +++
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit_load_extend.sv | 38 +++
 rtl/load_store_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and encodings for the load/store unit.
// funct3 codes, FSM states and the legality helper.
package load_store_unit_pkg;

    localparam int LSU_DATA_WIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

    // Unsigned variants exist only for loads.
    function automatic logic lsu_legal(
        input logic [2:0] f3,
        input logic [1:0] a,
        input logic       st
    );
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~a[0];
            F3_LW:   ok = (a == 2'b00);
            F3_LBU:  ok = ~st;
            F3_LHU:  ok = ~st & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned memory bus between the LSU and data memory.
// Request channel with valid/ready, response with valid only.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [LSU_DATA_WIDTH-1:0] mem_addr;
    logic                      mem_we;
    logic [3:0]                mem_wstrb;
    logic [LSU_DATA_WIDTH-1:0] mem_wdata;
    logic                      mem_rsp_valid;
    logic [LSU_DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_we,
        output mem_wstrb, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_we,
        input  mem_wstrb, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/half out of a bus word
// and sign- or zero-extends it per funct3.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = mem_rdata_i[7:0];
        case (addr_i)
            2'd1:    b = mem_rdata_i[15:8];
            2'd2:    b = mem_rdata_i[23:16];
            2'd3:    b = mem_rdata_i[31:24];
            default: b = mem_rdata_i[7:0];
        endcase
        h = addr_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    end

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_LB:   data_o = {{24{b[7]}}, b};
            F3_LH:   data_o = {{16{h[15]}}, h};
            F3_LW:   data_o = mem_rdata_i;
            F3_LBU:  data_o = {24'd0, b};
            F3_LHU:  data_o = {16'd0, h};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: checks alignment, issues one bus
// transaction per access and stalls the pipe until it completes.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [2:0]            AddressingControlM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  AccessFaultM,
    load_store_unit_if.master     mem
);

    lsu_state_e state_q, state_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  f3_q, f3_d;
    logic        store_q, store_d;

    logic        start;
    logic        legal;
    logic [31:0] ext;

    assign start = MemReadM | MemWriteM;
    assign legal = lsu_legal(AddressingControlM, ALUResultM[1:0], MemWriteM);

    load_extend u_ext (
        .mem_rdata_i (mem.mem_rdata),
        .addr_i      (addr_q[1:0]),
        .funct3_i    (f3_q),
        .data_o      (ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wd_q     <= '0;
            result_q <= '0;
            f3_q     <= '0;
            store_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            store_q  <= store_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        result_d = result_q;
        f3_d     = f3_q;
        store_d  = store_q;
        unique case (state_q)
            IDLE: begin
                if (start && legal) begin
                    state_d  = REQ;
                    addr_d   = ALUResultM;
                    wd_d     = WriteDataM;
                    f3_d     = AddressingControlM;
                    store_d  = MemWriteM;
                    result_d = '0;
                end
            end
            REQ: begin
                if (mem.mem_req_ready)
                    state_d = store_q ? DONE : WAIT;
            end
            WAIT: begin
                if (mem.mem_rsp_valid) begin
                    result_d = ext;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req_valid = 1'b0;
        mem.mem_addr      = {addr_q[31:2], 2'b00};
        mem.mem_we        = 1'b0;
        mem.mem_wstrb     = 4'b0000;
        mem.mem_wdata     = '0;
        StallM            = 1'b0;
        AccessFaultM      = 1'b0;
        ReadDataM         = '0;
        unique case (state_q)
            IDLE: begin
                StallM       = start & legal;
                AccessFaultM = start & ~legal;
            end
            REQ: begin
                StallM            = 1'b1;
                mem.mem_req_valid = 1'b1;
                mem.mem_we        = store_q;
                // Replicate store data so every enabled lane sees it.
                if (store_q) begin
                    case (f3_q)
                        F3_LB: begin
                            mem.mem_wstrb = 4'b0001 << addr_q[1:0];
                            mem.mem_wdata = {4{wd_q[7:0]}};
                        end
                        F3_LH: begin
                            mem.mem_wstrb = 4'b0011 << addr_q[1:0];
                            mem.mem_wdata = {2{wd_q[15:0]}};
                        end
                        F3_LW: begin
                            mem.mem_wstrb = 4'b1111;
                            mem.mem_wdata = wd_q;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT: StallM = 1'b1;
            DONE: ReadDataM = result_q;
        endcase
    end

endmodule
